// File: rtl/reg_serializer.sv
// reg_serializer: parallel-to-serial shifter with a valid/ready word input and done pulse
module reg_serializer #(
  parameter int WIDTH = 16,
  parameter bit MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0] cnt;
  logic last;
  assign last = cnt == CW'(WIDTH - 1);
  // state register; reset wins over any pending accept
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  // next state and outputs, all outputs forced low while reset is high
  always_comb begin
    state_n = state == IDLE ? (in_valid ? SHIFT : IDLE) :
              state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
    in_ready = !reset && state == IDLE;
    ser_valid = !reset && state == SHIFT;
    ser_out = ser_valid && (MSB_FIRST ? sr[WIDTH-1] : sr[0]);
    busy = !reset && (state == SHIFT || state == DONE);
    done = !reset && state == DONE;
  end
  // shift register and bit counter; counter saturates on the last bit so it never wraps
  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
      cnt <= '0;
    end else if (state == IDLE && in_valid) begin
      sr <= data_in;
      cnt <= '0;
    end else if (state == SHIFT) begin
      sr <= MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
      cnt <= last ? cnt : cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_reg_serializer.sv
// tb_reg_serializer: directed and random checks of three serializer configurations against a bit-stream model
module tb_reg_serializer;
  logic clk = 0;
  logic reset = 1;
  logic iv[3];
  logic [15:0] din[3];
  logic so[3], sv[3], bz[3], dn[3], rdy[3];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int s0, s1;
  logic [15:0] w;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  reg_serializer #(.WIDTH(16), .MSB_FIRST(1)) d_msb (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(rdy[0]), .data_in(din[0]),
    .ser_out(so[0]), .ser_valid(sv[0]), .busy(bz[0]), .done(dn[0]));
  reg_serializer #(.WIDTH(16), .MSB_FIRST(0)) d_lsb (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(rdy[1]), .data_in(din[1]),
    .ser_out(so[1]), .ser_valid(sv[1]), .busy(bz[1]), .done(dn[1]));
  reg_serializer #(.WIDTH(4), .MSB_FIRST(1)) d_w4 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(rdy[2]), .data_in(din[2][3:0]),
    .ser_out(so[2]), .ser_valid(sv[2]), .busy(bz[2]), .done(dn[2]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic outs(input string tag, input int k, input logic r, input logic v, input logic o,
                      input logic b, input logic d);
    chk({tag, ".in_ready"}, 32'(rdy[k]), 32'(r));
    chk({tag, ".ser_valid"}, 32'(sv[k]), 32'(v));
    chk({tag, ".ser_out"}, 32'(so[k]), 32'(o));
    chk({tag, ".busy"}, 32'(bz[k]), 32'(b));
    chk({tag, ".done"}, 32'(dn[k]), 32'(d));
  endtask
  function automatic logic model_bit(input logic [15:0] x, input int wid, input bit msb, input int i);
    return msb ? x[wid-1-i] : x[i];
  endfunction
  task automatic xfer(input string tag, input int k, input logic [15:0] x, input int wid, input bit msb,
                      input bit hold, input logic [15:0] nxt, output int start);
    outs({tag, ".idle"}, k, 1, 0, 0, 0, 0);
    iv[k] = 1;
    din[k] = x;
    @(negedge clk);
    start = cyc;
    iv[k] = hold;
    din[k] = hold ? nxt : $urandom;
    for (int i = 0; i < wid; i++) begin
      outs($sformatf("%s.bit%0d", tag, i), k, 0, 1, model_bit(x, wid, msb, i), 1, 0);
      @(negedge clk);
    end
    outs({tag, ".done"}, k, 0, 0, 0, 1, 1);
    @(negedge clk);
    outs({tag, ".after"}, k, 1, 0, 0, 0, 0);
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      iv[k] = 0;
      din[k] = '0;
    end
    iv[0] = 1;
    din[0] = 16'hFFFF;
    repeat (3) @(negedge clk);
    outs("reset", 0, 0, 0, 0, 0, 0);
    outs("reset_w4", 2, 0, 0, 0, 0, 0);
    iv[0] = 0;
    reset = 0;
    @(negedge clk);
    outs("post_reset", 0, 1, 0, 0, 0, 0);
    xfer("aaaa", 0, 16'hAAAA, 16, 1, 0, 0, s0);
    xfer("f0f0", 0, 16'hF0F0, 16, 1, 1, 16'h1234, s0);
    xfer("1234", 0, 16'h1234, 16, 1, 0, 0, s1);
    chk("held_accept_gap", 32'(s1 - s0), 32'd18);
    xfer("lsb0001", 1, 16'h0001, 16, 0, 0, 0, s0);
    xfer("w4_1001", 2, 16'h0009, 4, 1, 0, 0, s0);
    xfer("w4_1001b", 2, 16'h0009, 4, 1, 0, 0, s0);
    xfer("0f0f", 0, 16'h0F0F, 16, 1, 1, 16'hFFFF, s0);
    xfer("ffff", 0, 16'hFFFF, 16, 1, 0, 0, s1);
    chk("b2b_period", 32'(s1 - s0), 32'd18);
    iv[0] = 1;
    din[0] = 16'h5555;
    @(negedge clk);
    iv[0] = 0;
    for (int i = 0; i < 5; i++) begin
      outs($sformatf("abort.bit%0d", i), 0, 0, 1, model_bit(16'h5555, 16, 1, i), 1, 0);
      @(negedge clk);
    end
    reset = 1;
    @(negedge clk);
    outs("abort.reset", 0, 0, 0, 0, 0, 0);
    iv[0] = 1;
    din[0] = 16'hBEEF;
    @(negedge clk);
    outs("abort.reset2", 0, 0, 0, 0, 0, 0);
    reset = 0;
    iv[0] = 0;
    @(negedge clk);
    outs("abort.release", 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    outs("abort.no_accept", 0, 1, 0, 0, 0, 0);
    for (int n = 0; n < 12; n++) begin
      int k;
      k = n % 3;
      w = 16'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      xfer($sformatf("rnd%0d", n), k, k == 2 ? {12'h0, w[3:0]} : w, k == 2 ? 4 : 16, k != 1, 0, 0, s0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
